fdiv_round_pack: RTL and testbench

- Downstream neighbour of the pipelined restoring mantissa divider in the FP divide path.
- Carries sign, exponent and special-case class alongside the divider pipeline so they line up with its quotient.
- Normalizes the quotient, rounds to nearest-even using guard and sticky, and packs an IEEE-754 single result.
- Registers the packed result and status flags on the output.

---
 rtl/fdiv_round_pack.sv | 141 ++++++++++++++
 tb/tb_fdiv_round_pack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_round_pack.sv
// Final stage of the FP divide path: delays sign/exponent/class to meet the divider's quotient,
// then normalizes, rounds to nearest-even and packs an IEEE-754 single with status flags.
module fdiv_round_pack #(
   parameter int unsigned WIDTH  = 27,
   parameter int unsigned FRAC_W = 23,
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned LAT    = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_sign,
   input  logic [EXP_W+1:0]          in_exp,
   input  logic [1:0]                in_class,
   input  logic [WIDTH-1:0]          div_quot,
   input  logic                      div_sticky,
   input  logic                      div_done,
   output logic                      out_valid,
   output logic [EXP_W+FRAC_W:0]     out_result,
   output logic [2:0]                out_flags,
   output logic                      out_err
);
   localparam int unsigned EW   = EXP_W + 2;
   localparam int unsigned LowW = WIDTH - FRAC_W - 3;
   localparam int unsigned RW   = EXP_W + FRAC_W + 1;
   localparam logic signed [EW-1:0] EMax  = EW'((2 ** EXP_W) - 1);
   localparam logic signed [EW-1:0] EZero = '0;

   logic [LAT-1:0] vld_q, vld_d, sgn_q, sgn_d;
   logic [EW-1:0]  exp_q [LAT];
   logic [EW-1:0]  exp_d [LAT];
   logic [1:0]     cls_q [LAT];
   logic [1:0]     cls_d [LAT];

   logic          out_valid_q, out_valid_d, out_err_q, out_err_d;
   logic [RW-1:0] out_result_q, out_result_d;
   logic [2:0]    out_flags_q, out_flags_d;

   always_comb begin
      vld_d    = vld_q;
      sgn_d    = sgn_q;
      exp_d    = exp_q;
      cls_d    = cls_q;
      vld_d[0] = in_valid;
      sgn_d[0] = in_sign;
      exp_d[0] = in_exp;
      cls_d[0] = in_class;
      for (int unsigned i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         sgn_d[i] = sgn_q[i-1];
         exp_d[i] = exp_q[i-1];
         cls_d[i] = cls_q[i-1];
      end
   end

   logic                 hi, no_lead, g, s, inc, fire, t_sgn;
   logic [WIDTH-1:0]     qn;
   logic [FRAC_W:0]      mant;
   logic [FRAC_W+1:0]    mant_r;
   logic signed [EW-1:0] e_norm, e_fin;

   always_comb begin
      t_sgn   = sgn_q[LAT-1];
      hi      = div_quot[WIDTH-2];
      no_lead = ~div_quot[WIDTH-2] & ~div_quot[WIDTH-3];
      qn      = hi ? div_quot : (div_quot << 1);
      mant    = qn[WIDTH-2 -: FRAC_W+1];
      g       = qn[LowW];
      s       = (|qn[LowW-1:0]) | div_sticky;
      inc     = g & (s | mant[0]);
      mant_r  = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, inc};
      // Subtract 1 when the leading one sits at WIDTH-2, 2 when it sits one lower.
      e_norm  = exp_q[LAT-1] - {{(EW-2){1'b0}}, ~hi, hi};
      // On carry-out mant_r is 10..0, so its low FRAC_W bits are already the zero fraction.
      e_fin   = e_norm + {{(EW-1){1'b0}}, mant_r[FRAC_W+1]};
      fire    = vld_q[LAT-1] & div_done;

      out_valid_d  = fire;
      out_err_d    = out_err_q | (vld_q[LAT-1] ^ div_done);
      out_result_d = out_result_q;
      out_flags_d  = out_flags_q;
      if (fire) begin
         unique case (cls_q[LAT-1])
            2'b01: begin
               out_result_d = {t_sgn, {(RW-1){1'b0}}};
               out_flags_d  = 3'b000;
            end
            2'b10: begin
               out_result_d = {t_sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               out_flags_d  = 3'b000;
            end
            2'b11: begin
               out_result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
               out_flags_d  = 3'b000;
            end
            default: begin
               if (no_lead || e_fin <= EZero) begin
                  out_result_d = {t_sgn, {(RW-1){1'b0}}};
                  out_flags_d  = 3'b011;
               end else if (e_fin >= EMax) begin
                  out_result_d = {t_sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                  out_flags_d  = 3'b101;
               end else begin
                  out_result_d = {t_sgn, e_fin[EXP_W-1:0], mant_r[FRAC_W-1:0]};
                  out_flags_d  = {2'b00, g | s};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q        <= '0;
         sgn_q        <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            exp_q[i] <= '0;
            cls_q[i] <= '0;
         end
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
      end else begin
         vld_q        <= vld_d;
         sgn_q        <= sgn_d;
         exp_q        <= exp_d;
         cls_q        <= cls_d;
         out_valid_q  <= out_valid_d;
         out_err_q    <= out_err_d;
         out_result_q <= out_result_d;
         out_flags_q  <= out_flags_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_flags  = out_flags_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_fdiv_round_pack.sv
// Bench for fdiv_round_pack: models the divider timing, predicts packed results with integer
// rounding arithmetic, and checks every output on every cycle.
module tb_fdiv_round_pack;
   localparam int W  = 27;
   localparam int F  = 23;
   localparam int EW = 8;
   localparam int L  = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_sign, div_sticky, div_done;
   logic [EW+1:0] in_exp;
   logic [1:0]    in_class;
   logic [W-1:0]  div_quot;
   logic          out_valid, out_err;
   logic [31:0]   out_result;
   logic [2:0]    out_flags;

   always #5 clk = ~clk;

   fdiv_round_pack #(.WIDTH(W), .FRAC_W(F), .EXP_W(EW), .LAT(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign), .in_exp(in_exp),
      .in_class(in_class), .div_quot(div_quot), .div_sticky(div_sticky), .div_done(div_done),
      .out_valid(out_valid), .out_result(out_result), .out_flags(out_flags), .out_err(out_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit           sch_v [256];
   logic [W-1:0] sch_q [256];
   bit           sch_s [256];
   bit           ex_v  [256];
   bit           ex_e  [256];
   logic [31:0]  ex_r  [256];
   logic [2:0]   ex_f  [256];
   logic [31:0]  cur_r;
   logic [2:0]   cur_f;
   bit           exp_err;
   bit           force_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, want);
      end
   endtask

   // Rounds by comparing the discarded remainder against half an ulp.
   function automatic void model(input bit sg, input int ex, input bit [1:0] cl,
                                 input longint q, input bit st,
                                 output logic [31:0] r, output logic [2:0] fl);
      longint m, rem, half, top;
      int     k, e;
      bit     up, inex;
      fl = 3'b000;
      if (cl == 2'd1) begin r = {sg, 31'd0}; return; end
      if (cl == 2'd2) begin r = {sg, 8'hFF, 23'd0}; return; end
      if (cl == 2'd3) begin r = 32'h7FC00000; return; end
      top = longint'(1) << (W - 2);
      if (q >= top) begin k = W - 2 - F; e = ex - 1; end
      else if (q >= top / 2) begin k = W - 3 - F; e = ex - 2; end
      else begin r = {sg, 31'd0}; fl = 3'b011; return; end
      m    = q >> k;
      rem  = q - (m << k);
      half = longint'(1) << (k - 1);
      up   = (rem > half) || (rem == half && (st || m % 2 == 1));
      inex = (rem != 0) || st;
      m    = m + (up ? 1 : 0);
      if (m == (longint'(1) << (F + 1))) begin m = m >> 1; e = e + 1; end
      if (e >= 255) begin r = {sg, 8'hFF, 23'd0}; fl = 3'b101; end
      else if (e <= 0) begin r = {sg, 31'd0}; fl = 3'b011; end
      else begin r = {sg, 8'(e), 23'(m)}; fl = {2'b00, inex}; end
   endfunction

   task automatic run_cycle(input bit iv, input bit sg, input int ex, input bit [1:0] cl,
                            input logic [W-1:0] q, input bit st, input bit drop,
                            input bit use_want, input logic [31:0] wr, input logic [2:0] wf);
      logic [31:0] r;
      logic [2:0]  f;
      int          slot;
      in_valid = iv;
      in_sign  = sg;
      in_exp   = ex[EW+1:0];
      in_class = cl;
      if (iv) begin
         if (drop) ex_e[(cyc + L + 1) % 256] = 1'b1;
         else begin
            slot = (cyc + L) % 256;
            sch_v[slot] = 1'b1;
            sch_q[slot] = q;
            sch_s[slot] = st;
            model(sg, ex, cl, longint'(q), st, r, f);
            if (use_want) begin r = wr; f = wf; end
            slot = (cyc + L + 1) % 256;
            ex_v[slot] = 1'b1;
            ex_r[slot] = r;
            ex_f[slot] = f;
         end
      end
      slot       = cyc % 256;
      div_done   = sch_v[slot] | force_done;
      div_quot   = sch_q[slot];
      div_sticky = sch_s[slot];
      if (force_done && !sch_v[slot]) ex_e[(cyc + 1) % 256] = 1'b1;
      sch_v[slot] = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      slot = cyc % 256;
      if (ex_e[slot]) exp_err = 1'b1;
      if (ex_v[slot]) begin cur_r = ex_r[slot]; cur_f = ex_f[slot]; end
      chk("out_valid", 32'(out_valid), 32'(ex_v[slot]));
      chk("out_result", out_result, cur_r);
      chk("out_flags", 32'(out_flags), 32'(cur_f));
      chk("out_err", 32'(out_err), 32'(exp_err));
      ex_v[slot] = 1'b0;
      ex_e[slot] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 2'd0, '0, 0, 0, 0, '0, '0);
   endtask

   task automatic issue_dir(input bit sg, input int ex, input bit [1:0] cl, input logic [W-1:0] q,
                            input bit st, input logic [31:0] wr, input logic [2:0] wf);
      run_cycle(1, sg, ex, cl, q, st, 0, 1, wr, wf);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      div_done = 1'b0;
      force_done = 1'b0;
      for (int i = 0; i < 256; i++) begin
         sch_v[i] = 1'b0; ex_v[i] = 1'b0; ex_e[i] = 1'b0;
      end
      exp_err = 1'b0;
      cur_r = '0;
      cur_f = '0;
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_flags", 32'(out_flags), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b1;
   endtask

   initial begin
      logic [W-1:0] q;
      int           ex, sel;
      bit [1:0]     cl;
      in_sign = 0; in_exp = '0; in_class = '0; div_quot = '0; div_sticky = 0;
      do_reset();

      issue_dir(0, 128, 2'd0, 27'h2000000, 0, 32'h3F800000, 3'b000);
      idle(14);
      issue_dir(0, 128, 2'd0, 27'h2000002, 0, 32'h3F800000, 3'b001);
      issue_dir(0, 128, 2'd0, 27'h2000006, 0, 32'h3F800002, 3'b001);
      issue_dir(0, 128, 2'd0, 27'h3FFFFFE, 1, 32'h40000000, 3'b001);
      issue_dir(0, 256, 2'd0, 27'h2000000, 0, 32'h7F800000, 3'b101);
      issue_dir(0, 1,   2'd0, 27'h2000000, 0, 32'h00000000, 3'b011);
      issue_dir(1, 128, 2'd3, 27'h2000000, 0, 32'h7FC00000, 3'b000);
      issue_dir(1, 128, 2'd1, 27'h2000000, 0, 32'h80000000, 3'b000);
      issue_dir(1, 128, 2'd2, 27'h2000000, 0, 32'hFF800000, 3'b000);
      issue_dir(1, 129, 2'd0, 27'h1000000, 0, 32'hBF800000, 3'b000);
      issue_dir(0, 128, 2'd0, 27'h0000000, 0, 32'h00000000, 3'b011);
      idle(14);

      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         cl  = (sel == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         sel = $urandom_range(0, 9);
         q   = W'($urandom) & 27'h0FFFFFF;
         if (sel < 6) q[25] = 1'b1;
         else if (sel < 9) q[24] = 1'b1;
         ex  = int'($urandom_range(0, 300)) - 20;
         run_cycle($urandom_range(0, 3) != 0, 1'($urandom), ex, cl, q, 1'($urandom), 0, 0,
                   '0, '0);
      end
      idle(14);

      // Five back-to-back ops, then reset while all are still in flight.
      for (int n = 0; n < 5; n++)
         run_cycle(1, 0, 128, 2'd0, 27'h2000000 | W'(n), 0, 0, 0, '0, '0);
      do_reset();
      idle(16);

      run_cycle(1, 0, 128, 2'd0, 27'h2000000, 0, 1, 0, '0, '0);
      idle(16);
      do_reset();

      force_done = 1'b1;
      idle(1);
      force_done = 1'b0;
      idle(6);
      do_reset();
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
